// File: rtl/router_pkg.sv
// router_pkg: shared state encoding, constants and header helper for the router packet transmitter
package router_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, HDR, PAYLOAD, PARITY, WAIT} tx_state_e;
    localparam logic [1:0] ADDR_ILLEGAL = 2'b11;
    localparam int MAX_LEN = 63;
    function automatic logic [7:0] make_header(input logic [1:0] addr, input logic [5:0] len);
        return {len, addr};
    endfunction
endpackage

// File: rtl/router_tx_buf.sv
// router_tx_buf: 64x8 payload buffer, synchronous write and combinational read
module router_tx_buf
    import router_pkg::*;
(
    input  logic       clock,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data
);
    logic [7:0] mem [MAX_LEN+1];
    always_ff @(posedge clock)
        if (wr_en) mem[wr_addr] <= wr_data;
    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: stages a command and payload, then streams header/payload/parity to the router under busy
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int CHK_CYCLES = 2
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_addr,
    input  logic [5:0] cmd_len,
    input  logic       cmd_corrupt,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic [7:0] pl_data,
    input  logic       busy,
    input  logic       error,
    output logic [7:0] data_in,
    output logic       pkt_valid,
    output logic       cmd_rej,
    output logic       tx_done,
    output logic       tx_err
);
    tx_state_e  state, state_d;
    logic [1:0] addr, addr_d;
    logic [5:0] len, len_d, wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d, rd_addr;
    logic [7:0] parity, parity_d, data_d, rd_data;
    logic [2:0] cnt, cnt_d;
    logic       corrupt, corrupt_d, pv_d, rej_d, done_d, err_d, wr_en;
    assign cmd_ready = state == IDLE;
    assign pl_ready  = state == LOAD;
    router_tx_buf u_buf (
        .clock  (clock),
        .wr_en  (wr_en),
        .wr_addr(wr_ptr),
        .wr_data(pl_data),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            addr      <= '0;
            len       <= '0;
            corrupt   <= 1'b0;
            parity    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            data_in   <= '0;
            pkt_valid <= 1'b0;
            cmd_rej   <= 1'b0;
            tx_done   <= 1'b0;
            tx_err    <= 1'b0;
        end else begin
            state     <= state_d;
            addr      <= addr_d;
            len       <= len_d;
            corrupt   <= corrupt_d;
            parity    <= parity_d;
            wr_ptr    <= wr_ptr_d;
            rd_ptr    <= rd_ptr_d;
            cnt       <= cnt_d;
            data_in   <= data_d;
            pkt_valid <= pv_d;
            cmd_rej   <= rej_d;
            tx_done   <= done_d;
            tx_err    <= err_d;
        end
    end
    always_comb begin
        state_d   = state;
        addr_d    = addr;
        len_d     = len;
        corrupt_d = corrupt;
        parity_d  = parity;
        wr_ptr_d  = wr_ptr;
        rd_ptr_d  = rd_ptr;
        cnt_d     = cnt;
        data_d    = data_in;
        pv_d      = pkt_valid;
        rej_d     = 1'b0;
        done_d    = 1'b0;
        err_d     = tx_err;
        wr_en     = 1'b0;
        rd_addr   = 6'd0;
        case (state)
            IDLE: if (cmd_valid) begin
                addr_d    = cmd_addr;
                len_d     = cmd_len;
                corrupt_d = cmd_corrupt;
                parity_d  = make_header(cmd_addr, cmd_len);
                wr_ptr_d  = 6'd0;
                rd_ptr_d  = 6'd0;
                if (cmd_addr == ADDR_ILLEGAL || cmd_len == 6'd0) rej_d = 1'b1;
                else state_d = LOAD;
            end
            LOAD: if (pl_valid) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr + 6'd1;
                parity_d = parity ^ pl_data;
                if (wr_ptr == len - 6'd1) begin
                    state_d = HDR;
                    data_d  = make_header(addr, len);
                    pv_d    = 1'b1;
                end
            end
            HDR: if (!busy) begin
                data_d  = rd_data;
                state_d = PAYLOAD;
            end
            PAYLOAD: begin
                // look one byte ahead so the next payload byte is ready at the consume edge
                rd_addr = rd_ptr + 6'd1;
                if (!busy) begin
                    if (rd_ptr == len - 6'd1) begin
                        data_d  = corrupt ? ~parity : parity;
                        pv_d    = 1'b0;
                        state_d = PARITY;
                    end else begin
                        rd_ptr_d = rd_ptr + 6'd1;
                        data_d   = rd_data;
                    end
                end
            end
            PARITY: if (!busy) begin
                data_d  = 8'd0;
                cnt_d   = 3'd0;
                state_d = WAIT;
            end
            WAIT: begin
                if (tx_done) state_d = IDLE;
                else if (cnt == 3'(CHK_CYCLES)) begin
                    done_d = 1'b1;
                    err_d  = error;
                end else cnt_d = cnt + 3'd1;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: table-driven, randomized and reset-corner checks of router_pkt_tx against a byte-stream model
module tb_router_pkt_tx;
    localparam int CHK = 2;
    logic       clock = 0, rst = 0, cmd_valid = 0, cmd_corrupt = 0, pl_valid = 0, busy = 0, error = 0;
    logic [1:0] cmd_addr = 0;
    logic [5:0] cmd_len = 0;
    logic [7:0] pl_data = 0;
    logic       cmd_ready, pl_ready, pkt_valid, cmd_rej, tx_done, tx_err;
    logic [7:0] data_in;
    int checks = 0, failures = 0;

    router_pkt_tx #(.CHK_CYCLES(CHK)) dut (
        .clock(clock), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_corrupt(cmd_corrupt),
        .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
        .busy(busy), .error(error), .data_in(data_in), .pkt_valid(pkt_valid),
        .cmd_rej(cmd_rej), .tx_done(tx_done), .tx_err(tx_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] a;
        logic [5:0] n;
        logic       c, e;
        int         bmode, gap;
        logic [7:0] p0, p1, p2;
        logic       rej;
        logic [7:0] hdr;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic run_rej(input logic [1:0] a, input logic [5:0] n);
        @(negedge clock);
        cmd_valid = 1; cmd_addr = a; cmd_len = n; cmd_corrupt = 0;
        @(negedge clock);
        cmd_valid = 0;
        chk("rej_pulse", cmd_rej, 1);
        chk("rej_ready", cmd_ready, 1);
        chk("rej_no_valid", pkt_valid, 0);
        @(negedge clock);
        chk("rej_single", cmd_rej, 0);
        chk("rej_stay_idle", {cmd_ready, pl_ready, pkt_valid}, 3'b100);
    endtask

    // bmode: 0 never busy, 1 random busy, 2 busy for two cycles after the header appears
    task automatic run_pkt(input logic [1:0] a, input logic [5:0] n, input logic c, input logic e,
                           input int bmode, input int gap, input logic [7:0] p0, p1, p2,
                           input logic [7:0] exp_hdr);
        logic [7:0] pl[$], exp_q[$], got[$];
        logic [7:0] par, obs_d, prev_d;
        logic obs_v, prev_v, b, pv, prev_b, prev_pres, pres, hold_ok, rdy_ok, rej_ok, err_seen, rdy_done;
        int acc, cyc, hs_cyc, hdr_cyc, par_cyc, done_cyc, bad;
        for (int i = 0; i < n; i++) pl.push_back(i == 0 ? p0 : i == 1 ? p1 : i == 2 ? p2 : 8'($urandom));
        par = {n, a};
        exp_q.push_back(par);
        foreach (pl[i]) begin
            exp_q.push_back(pl[i]);
            par ^= pl[i];
        end
        exp_q.push_back(c ? ~par : par);
        @(negedge clock);
        chk("ready_idle", cmd_ready, 1);
        cmd_valid = 1; cmd_addr = a; cmd_len = n; cmd_corrupt = c; error = e;
        acc = 0; cyc = 0; hs_cyc = -100; hdr_cyc = -1; par_cyc = -1; done_cyc = -1;
        prev_b = 0; prev_pres = 0; prev_d = 0; prev_v = 0;
        hold_ok = 1; rdy_ok = 1; rej_ok = 1; err_seen = 0; rdy_done = 1;
        @(posedge clock);
        while (done_cyc < 0 && cyc < 3000) begin
            @(negedge clock);
            cyc++;
            obs_d = data_in; obs_v = pkt_valid;
            if (tx_done) begin
                done_cyc = cyc; err_seen = tx_err; rdy_done = cmd_ready;
            end
            if (cmd_rej) rej_ok = 0;
            if ((acc < n) != pl_ready) rdy_ok = 0;
            if (obs_v && hdr_cyc < 0) hdr_cyc = cyc;
            if (prev_b && prev_pres && (obs_d !== prev_d || obs_v !== prev_v)) hold_ok = 0;
            pres = hdr_cyc >= 0 && par_cyc < 0;
            b = bmode == 0 ? 1'b0 : bmode == 1 ? ($urandom_range(0, 9) < 4) : (hdr_cyc >= 0 && cyc - hdr_cyc < 2);
            pv = gap != 0 ? ($urandom_range(0, 3) != 0) : 1'b1;
            busy = b; pl_valid = pv;
            pl_data = (pv && acc < n) ? pl[acc] : 8'($urandom);
            cmd_valid = gap != 0 ? 1'($urandom) : 1'b0;
            cmd_addr = 2'($urandom); cmd_len = 6'($urandom); cmd_corrupt = 1'($urandom);
            @(posedge clock);
            if (pv && acc < n) begin
                acc++;
                if (acc == n) hs_cyc = cyc;
            end
            if (pres && !b) begin
                got.push_back(obs_d);
                if (!obs_v) par_cyc = cyc;
            end
            prev_b = b; prev_pres = pres; prev_d = obs_d; prev_v = obs_v;
        end
        cmd_valid = 0; pl_valid = 0; busy = 0;
        chk("done_seen", done_cyc >= 0, 1);
        chk("hdr_latency", hdr_cyc - hs_cyc, 1);
        chk("stream_len", got.size(), exp_q.size());
        bad = 0;
        foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) bad++;
        chk("stream_bytes_bad", bad, 0);
        if (got.size() > 0) chk("hdr_byte", got[0], exp_hdr);
        if (got.size() == exp_q.size()) chk("parity_byte", got[got.size()-1], exp_q[exp_q.size()-1]);
        chk("done_latency", done_cyc - par_cyc, CHK + 2);
        chk("tx_err", err_seen, e);
        chk("ready_low_at_done", rdy_done, 0);
        chk("busy_hold", hold_ok, 1);
        chk("pl_ready_window", rdy_ok, 1);
        chk("no_rej_in_pkt", rej_ok, 1);
        @(negedge clock);
        error = 0;
        chk("done_single", tx_done, 0);
        chk("ready_after_done", cmd_ready, 1);
    endtask

    initial begin
        logic [1:0] a;
        logic [5:0] n;
        int seen;
        tbl[0] = '{2'd1, 6'd3,  1'b0, 1'b0, 0, 0, 8'h11, 8'h22, 8'h33, 1'b0, 8'h0D};
        tbl[1] = '{2'd1, 6'd3,  1'b0, 1'b0, 2, 0, 8'h11, 8'h22, 8'h33, 1'b0, 8'h0D};
        tbl[2] = '{2'd3, 6'd5,  1'b0, 1'b0, 0, 0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00};
        tbl[3] = '{2'd0, 6'd0,  1'b0, 1'b0, 0, 0, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00};
        tbl[4] = '{2'd2, 6'd1,  1'b1, 1'b1, 0, 0, 8'hAA, 8'h00, 8'h00, 1'b0, 8'h06};
        tbl[5] = '{2'd0, 6'd63, 1'b0, 1'b0, 1, 1, 8'h5A, 8'hA5, 8'h3C, 1'b0, 8'hFC};
        tbl[6] = '{2'd2, 6'd63, 1'b1, 1'b0, 1, 1, 8'hFF, 8'h00, 8'h81, 1'b0, 8'hFE};
        tbl[7] = '{2'd0, 6'd1,  1'b0, 1'b1, 1, 0, 8'h7E, 8'h00, 8'h00, 1'b0, 8'h04};
        #12;
        chk("reset_outputs", {data_in, pkt_valid, pl_ready, cmd_rej, tx_done, tx_err}, 13'h0);
        chk("reset_ready", cmd_ready, 1);
        @(negedge clock);
        rst = 1;
        foreach (tbl[i]) begin
            if (tbl[i].rej) run_rej(tbl[i].a, tbl[i].n);
            else run_pkt(tbl[i].a, tbl[i].n, tbl[i].c, tbl[i].e, tbl[i].bmode, tbl[i].gap,
                         tbl[i].p0, tbl[i].p1, tbl[i].p2, tbl[i].hdr);
        end
        for (int k = 0; k < 8; k++) begin
            a = 2'($urandom);
            n = 6'($urandom);
            if (a == 2'd3 || n == 6'd0) run_rej(a, n);
            else run_pkt(a, n, 1'($urandom), 1'($urandom), 1, 1,
                         8'($urandom), 8'($urandom), 8'($urandom), {n, a});
        end
        // reset asserted while payload bytes are on the bus
        @(negedge clock);
        cmd_valid = 1; cmd_addr = 0; cmd_len = 8; cmd_corrupt = 0;
        seen = 0;
        for (int i = 0; i < 60 && seen < 3; i++) begin
            @(negedge clock);
            cmd_valid = 0; pl_valid = 1; pl_data = 8'(i + 1);
            if (pkt_valid) seen++;
        end
        pl_valid = 0;
        chk("rst_reach_payload", seen, 3);
        #2 rst = 0;
        #1;
        chk("rst_async_data", data_in, 0);
        chk("rst_async_valid", pkt_valid, 0);
        chk("rst_async_ready", cmd_ready, 1);
        @(negedge clock);
        rst = 1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (tx_done || pkt_valid) seen++;
        end
        chk("rst_abandoned", seen, 0);
        run_pkt(2'd1, 6'd3, 1'b0, 1'b0, 0, 0, 8'h11, 8'h22, 8'h33, 8'h0D);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
